// File: rtl/hv_item_memory_gen.sv
// hv_item_memory_gen
// ------------------
// LFSR-driven hypervector generator for the HDC item memory. Each run produces
// NUM_HV hypervectors of width DIM. Each one is built by shifting LFSR output
// bits into a running hypervector register for SHIFTS_PER_HV clocks. Each of
// those clocks performs BITS_PER_CYCLE chained LFSR steps. Every finished
// hypervector is held on a valid/ready interface until the consumer accepts it.
//
// Ports
//   clk        rising-edge clock
//   nrst       asynchronous active-low reset
//   start      begin a run (IDLE only); cont=1 keeps LFSR/HV, cont=0 reloads
//   cont       qualifies start: continue (1) or restart from seed (0)
//   abort      synchronous return to IDLE; LFSR and HV contents are kept
//   seed_load  write seed_in to the seed register (IDLE only; 0 maps to SEED)
//   seed_in    runtime seed
//   hv_out     hypervector register, always visible
//   hv_valid   hv_out holds a completed hypervector
//   hv_ready   consumer accepts hv_out
//   hv_index   index of the hypervector being presented
//   busy       high while in FILL or PRESENT
//   done       one-cycle pulse after the last handshake of a run
module hv_item_memory_gen #(
  parameter int                    NUM_REGS       = 16,
  parameter logic [NUM_REGS-1:0]   TAPS           = 16'b1101000000001000,
  parameter logic [NUM_REGS-1:0]   SEED           = 16'b1001010010110101,
  parameter int                    DIM            = 10000,
  parameter logic [DIM-1:0]        START_VAL      = '0,
  parameter int                    BITS_PER_CYCLE = 1,
  parameter int                    SHIFTS_PER_HV  = 1,
  parameter int                    NUM_HV         = 4,
  localparam int                   IDX_W          = (NUM_HV > 1) ? $clog2(NUM_HV) : 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  input  logic                cont,
  input  logic                abort,
  input  logic                seed_load,
  input  logic [NUM_REGS-1:0] seed_in,
  output logic [DIM-1:0]      hv_out,
  output logic                hv_valid,
  input  logic                hv_ready,
  output logic [IDX_W-1:0]    hv_index,
  output logic                busy,
  output logic                done
);

  localparam int                CNT_W    = $clog2(SHIFTS_PER_HV + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SHIFTS_PER_HV - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_HV - 1);

  typedef enum logic [1:0] {IDLE, FILL, PRESENT} state_t;

  state_t              state, next_state;
  logic [NUM_REGS-1:0] seed_reg;
  logic [NUM_REGS-1:0] lfsr;
  logic [DIM-1:0]      hv;
  logic [CNT_W-1:0]    cnt;

  logic [NUM_REGS-1:0] lfsr_burst;
  logic [DIM-1:0]      hv_burst;

  // One clock's worth of LFSR steps, chained in order. Bit NUM_REGS-1 leaves
  // the LFSR and enters the LSB of the hypervector; feedback enters the LSB.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // logic, so no path leaves it unassigned and no latch is inferred.
    lfsr_burst = lfsr;
    hv_burst   = hv;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      hv_burst   = {hv_burst[DIM-2:0], lfsr_burst[NUM_REGS-1]};
      lfsr_burst = {lfsr_burst[NUM_REGS-2:0], ^(lfsr_burst & TAPS)};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = FILL;
      FILL:    if (cnt == LAST_CNT) next_state = PRESENT;
      PRESENT: if (hv_ready) next_state = (hv_index == LAST_IDX) ? IDLE : FILL;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    if (!nrst) begin
      seed_reg <= SEED;
      lfsr     <= SEED;
      hv       <= START_VAL;
      cnt      <= '0;
      hv_index <= '0;
      hv_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;

      // Seed writes are independent of start. A same-cycle start still reads
      // the old seed_reg value, so the new seed applies from the next run.
      if (state == IDLE && seed_load) begin
        seed_reg <= (seed_in == '0) ? SEED : seed_in;
      end

      if (abort) begin
        hv_valid <= 1'b0;
        hv_index <= '0;
        cnt      <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              cnt      <= '0;
              hv_index <= '0;
              if (!cont) begin
                lfsr <= seed_reg;
                hv   <= START_VAL;
              end
            end
          end
          FILL: begin
            lfsr <= lfsr_burst;
            hv   <= hv_burst;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST_CNT) hv_valid <= 1'b1;
          end
          PRESENT: begin
            // LFSR and hv hold here, both while stalled and on the handshake.
            if (hv_ready) begin
              hv_valid <= 1'b0;
              cnt      <= '0;
              if (hv_index == LAST_IDX) begin
                done <= 1'b1;
              end else begin
                hv_index <= hv_index + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign hv_out = hv;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_hv_item_memory_gen.sv
// tb_hv_item_memory_gen
// ---------------------
// Directed bench for hv_item_memory_gen with a 4-bit LFSR (taps 1100,
// seed 1001), DIM=8, START_VAL=A5, 2 shift cycles per hypervector and 3
// hypervectors per run. Expected hypervectors come from hand-stepping the LFSR.
module tb_hv_item_memory_gen;

  logic       clk = 1'b0;
  logic       nrst;
  logic       start, cont, abort, seed_load, hv_ready;
  logic [3:0] seed_in;
  logic [7:0] hv_out;
  logic       hv_valid;
  logic [1:0] hv_index;
  logic       busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  hv_item_memory_gen #(
    .NUM_REGS       (4),
    .TAPS           (4'b1100),
    .SEED           (4'b1001),
    .DIM            (8),
    .START_VAL      (8'hA5),
    .BITS_PER_CYCLE (1),
    .SHIFTS_PER_HV  (2),
    .NUM_HV         (3)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .cont      (cont),
    .abort     (abort),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .hv_out    (hv_out),
    .hv_valid  (hv_valid),
    .hv_ready  (hv_ready),
    .hv_index  (hv_index),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic c);
    start = 1'b1;
    cont  = c;
    step();
    start = 1'b0;
    cont  = 1'b0;
  endtask

  // Wait (bounded) for hv_valid, then check the presented hypervector.
  task automatic expect_hv(input string tag, input logic [7:0] exp_hv, input logic [1:0] exp_idx);
    int n = 0;
    while (!hv_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, " valid"}, hv_valid, 1'b1);
    check({tag, " hv"}, hv_out, exp_hv);
    check({tag, " idx"}, hv_index, exp_idx);
  endtask

  // Run with hv_ready=1 until done is seen (bounded).
  task automatic wait_done(input string tag);
    int   n    = 0;
    logic seen = 1'b0;
    hv_ready = 1'b1;
    while (!seen && n < 40) begin
      step();
      seen = done;
      n++;
    end
    check({tag, " done"}, seen, 1'b1);
  endtask

  initial begin
    nrst      = 1'b0;
    start     = 1'b0;
    cont      = 1'b0;
    abort     = 1'b0;
    seed_load = 1'b0;
    seed_in   = 4'h0;
    hv_ready  = 1'b1;
    step();
    step();

    // Reset state
    check("rst hv_valid", hv_valid, 1'b0);
    check("rst hv_out", hv_out, 8'hA5);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst hv_index", hv_index, 2'd0);
    nrst = 1'b1;
    step();

    // 1. Basic run with exact cycle timing
    pulse_start(1'b0);
    check("t1 busy", busy, 1'b1);
    check("t1 valid c1", hv_valid, 1'b0);
    step();
    check("t1 valid c2", hv_valid, 1'b0);
    step();
    check("t1 valid c3", hv_valid, 1'b1);
    check("t1 hv0", hv_out, 8'h96);
    check("t1 idx0", hv_index, 2'd0);
    step();
    check("t1 valid drop", hv_valid, 1'b0);
    step();
    step();
    check("t1 hv1", hv_out, 8'h59);
    check("t1 idx1", hv_index, 2'd1);
    step();
    step();
    step();
    check("t1 hv2", hv_out, 8'h66);
    check("t1 idx2", hv_index, 2'd2);
    check("t1 no early done", done, 1'b0);
    step();
    check("t1 done", done, 1'b1);
    check("t1 idle busy", busy, 1'b0);
    check("t1 idle valid", hv_valid, 1'b0);
    step();
    check("t1 done pulse", done, 1'b0);

    // 2. Backpressure on index 1
    pulse_start(1'b0);
    expect_hv("t2 hv0", 8'h96, 2'd0);
    step();
    hv_ready = 1'b0;
    expect_hv("t2 hv1", 8'h59, 2'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2 stall hv", hv_out, 8'h59);
      check("t2 stall valid", hv_valid, 1'b1);
    end
    hv_ready = 1'b1;
    step();
    expect_hv("t2 hv2", 8'h66, 2'd2);
    wait_done("t2");

    // 3. Continue from LFSR state 1011
    pulse_start(1'b1);
    expect_hv("t3 hv0", 8'h9A, 2'd0);
    wait_done("t3");

    // 4. Zero seed maps to SEED; a new seed written alongside start waits
    seed_load = 1'b1;
    seed_in   = 4'h0;
    step();
    seed_load = 1'b0;
    pulse_start(1'b0);
    expect_hv("t4 zero hv0", 8'h96, 2'd0);
    step();
    expect_hv("t4 zero hv1", 8'h59, 2'd1);
    step();
    expect_hv("t4 zero hv2", 8'h66, 2'd2);
    wait_done("t4 zero");
    seed_load = 1'b1;
    seed_in   = 4'b0001;
    pulse_start(1'b0);
    seed_load = 1'b0;
    expect_hv("t4 old seed hv0", 8'h96, 2'd0);
    wait_done("t4 old seed");
    pulse_start(1'b0);
    expect_hv("t4 reseed hv0", 8'h94, 2'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // 5. Abort during FILL of index 1
    seed_load = 1'b1;
    seed_in   = 4'h0;
    step();
    seed_load = 1'b0;
    pulse_start(1'b0);
    expect_hv("t5 hv0", 8'h96, 2'd0);
    step();
    check("t5 in fill idx", hv_index, 2'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5 abort busy", busy, 1'b0);
    check("t5 abort valid", hv_valid, 1'b0);
    check("t5 abort idx", hv_index, 2'd0);
    check("t5 abort done", done, 1'b0);
    step();
    check("t5 no done", done, 1'b0);
    pulse_start(1'b0);
    expect_hv("t5 restart hv0", 8'h96, 2'd0);

    // 6. Async reset while presenting
    hv_ready = 1'b0;
    step();
    check("t6 present valid", hv_valid, 1'b1);
    #2;
    nrst = 1'b0;
    #1;
    check("t6 async valid", hv_valid, 1'b0);
    check("t6 async hv", hv_out, 8'hA5);
    check("t6 async busy", busy, 1'b0);
    check("t6 async idx", hv_index, 2'd0);
    step();
    nrst = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
